// File: rtl/stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall bus layout,
// register address width, RAM-wait FSM encoding and a saturating-add helper
// for the optional performance counters (STALL_PERF_CNT_EN).
package stall_ctrl_pkg;

    localparam int STALL_BUS_WIDTH    = 6;
    localparam int REG_ADDR_BUS_WIDTH = 5;

    // Stage indices into the stall vector.
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef logic [STALL_BUS_WIDTH-1:0]    stall_vec_t;
    typedef logic [REG_ADDR_BUS_WIDTH-1:0] reg_addr_t;

    typedef enum logic {
        RAM_FSM_IDLE = 1'b0,
        RAM_FSM_WAIT = 1'b1
    } ram_fsm_e;

    localparam logic [31:0] PERF_CNT_MAX = 32'hFFFF_FFFF;

    // Increment that sticks at the maximum instead of wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == PERF_CNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Stall-controller bus: stall causes from IF/ID/EX/MEM in, stall vector and
// RAM timeout pulse out. With STALL_PERF_CNT_EN defined it also carries the
// stall_cycles and load_use_count counters.
interface stall_ctrl_if;
    import stall_ctrl_pkg::*;

    logic       stall_req_if;
    logic       id_read_en_1;
    reg_addr_t  id_read_addr_1;
    logic       id_read_en_2;
    reg_addr_t  id_read_addr_2;
    logic       ex_ram_read_flag;
    logic       ex_write_reg_en;
    reg_addr_t  ex_write_reg_addr;
    logic       ex_busy;
    logic       mem_ram_en;
    logic       mem_ram_ready;
    stall_vec_t stall;
    logic       ram_timeout;
`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] load_use_count;

    modport master (
        output stall_req_if, id_read_en_1, id_read_addr_1, id_read_en_2, id_read_addr_2,
               ex_ram_read_flag, ex_write_reg_en, ex_write_reg_addr, ex_busy,
               mem_ram_en, mem_ram_ready,
        input  stall, ram_timeout, stall_cycles, load_use_count
    );
    modport slave (
        input  stall_req_if, id_read_en_1, id_read_addr_1, id_read_en_2, id_read_addr_2,
               ex_ram_read_flag, ex_write_reg_en, ex_write_reg_addr, ex_busy,
               mem_ram_en, mem_ram_ready,
        output stall, ram_timeout, stall_cycles, load_use_count
    );
`else
    modport master (
        output stall_req_if, id_read_en_1, id_read_addr_1, id_read_en_2, id_read_addr_2,
               ex_ram_read_flag, ex_write_reg_en, ex_write_reg_addr, ex_busy,
               mem_ram_en, mem_ram_ready,
        input  stall, ram_timeout
    );
    modport slave (
        input  stall_req_if, id_read_en_1, id_read_addr_1, id_read_en_2, id_read_addr_2,
               ex_ram_read_flag, ex_write_reg_en, ex_write_reg_addr, ex_busy,
               mem_ram_en, mem_ram_ready,
        output stall, ram_timeout
    );
`endif

endinterface

// File: rtl/stall_ctrl_ram_wait_fsm.sv
// RAM wait-handshake FSM. Raises mem_wait in the same cycle a RAM access is
// not ready, and force-releases the wait with a one-cycle ram_timeout pulse
// after RAM_TIMEOUT consecutive wait cycles so a dead RAM cannot hang the core.
module stall_ctrl_ram_wait_fsm
    import stall_ctrl_pkg::*;
#(
    parameter int RAM_TIMEOUT       = 255,
    parameter int TIMEOUT_CNT_WIDTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_ram_en_i,
    input  logic mem_ram_ready_i,
    output logic mem_wait_o,
    output logic ram_timeout_o
);

    localparam logic [TIMEOUT_CNT_WIDTH-1:0] CNT_LIMIT = TIMEOUT_CNT_WIDTH'(RAM_TIMEOUT);
    localparam logic [TIMEOUT_CNT_WIDTH-1:0] CNT_ONE   = TIMEOUT_CNT_WIDTH'(1);

    ram_fsm_e                     state_q, state_d;
    logic [TIMEOUT_CNT_WIDTH-1:0] cnt_q, cnt_d;

    // State and wait counter registers; reset returns to IDLE from any state.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RAM_FSM_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and same-cycle mem_wait / ram_timeout outputs.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_wait_o    = 1'b0;
        ram_timeout_o = 1'b0;
        case (state_q)
            RAM_FSM_IDLE: begin
                if (mem_ram_en_i && !mem_ram_ready_i) begin
                    state_d    = RAM_FSM_WAIT;
                    cnt_d      = CNT_ONE;
                    mem_wait_o = 1'b1;
                end
            end
            RAM_FSM_WAIT: begin
                if (!mem_ram_en_i) begin
                    // Request withdrawn mid-wait: bus error, release silently.
                    state_d = RAM_FSM_IDLE;
                    cnt_d   = '0;
                end else if (mem_ram_ready_i) begin
                    // Ready wins over a coincident timeout.
                    state_d = RAM_FSM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d       = RAM_FSM_IDLE;
                    cnt_d         = '0;
                    ram_timeout_o = 1'b1;
                end else begin
                    mem_wait_o = 1'b1;
                    cnt_d      = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RAM_FSM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/stall_ctrl.sv
// Central pipeline stall controller. Combines IF, ID load-use, EX busy and
// MEM RAM-wait causes into a prefix stall vector with zero latency.
// Optional STALL_PERF_CNT_EN adds saturating stall-cycle and load-use counters.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int RAM_TIMEOUT       = 255,
    parameter int TIMEOUT_CNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    stall_ctrl_if.slave  bus
);

    logic       req_id;
    logic       mem_wait;
    stall_vec_t req;
    stall_vec_t stall_vec;
    logic       acc;

    stall_ctrl_ram_wait_fsm #(
        .RAM_TIMEOUT       (RAM_TIMEOUT),
        .TIMEOUT_CNT_WIDTH (TIMEOUT_CNT_WIDTH)
    ) u_ram_wait_fsm (
        .clk             (clk),
        .rst             (rst),
        .mem_ram_en_i    (bus.mem_ram_en),
        .mem_ram_ready_i (bus.mem_ram_ready),
        .mem_wait_o      (mem_wait),
        .ram_timeout_o   (bus.ram_timeout)
    );

    // Load-use hazard: EX holds a load whose destination ID is reading (r0 excluded).
    always_comb begin
        req_id = bus.ex_ram_read_flag && bus.ex_write_reg_en && (bus.ex_write_reg_addr != '0)
              && ((bus.id_read_en_1 && (bus.id_read_addr_1 == bus.ex_write_reg_addr))
               || (bus.id_read_en_2 && (bus.id_read_addr_2 == bus.ex_write_reg_addr)));
    end

    // Prefix encode: the highest requesting stage stalls itself and everything below.
    always_comb begin
        req            = '0;
        req[STALL_IF]  = bus.stall_req_if;
        req[STALL_ID]  = req_id;
        req[STALL_EX]  = bus.ex_busy;
        req[STALL_MEM] = mem_wait;
        acc            = 1'b0;
        stall_vec      = '0;
        for (int j = STALL_BUS_WIDTH - 1; j >= 0; j--) begin
            acc          = acc | req[j];
            stall_vec[j] = acc;
        end
    end

    assign bus.stall = stall_vec;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] load_use_count_q;

    // Saturating counters of PC-stalled cycles and load-use hazard cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_q   <= '0;
            load_use_count_q <= '0;
        end else begin
            if (stall_vec[STALL_PC]) stall_cycles_q   <= sat_inc(stall_cycles_q);
            if (req_id)              load_use_count_q <= sat_inc(load_use_count_q);
        end
    end

    assign bus.stall_cycles   = stall_cycles_q;
    assign bus.load_use_count = load_use_count_q;
`endif

endmodule

// File: doc/stall_ctrl.md
Name: stall_ctrl

Overview:
- Central pipeline stall controller for the 5-stage core.
- Collects stall causes from IF, ID (load-use), EX (multi-cycle op) and MEM (RAM wait handshake).
- Drives the per-stage stall vector consumed by every inter-stage PipelineDeliver register pair as stall_current_stage / stall_next_stage.
- Owns the RAM-wait FSM with a timeout, so a dead RAM cannot hang the core.

Parameters:
- RAM_TIMEOUT, 255: max consecutive RAM wait cycles before forced release; legal range 1..65535.
- TIMEOUT_CNT_WIDTH, 16: width of the wait counter; must hold RAM_TIMEOUT.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- stall_req_if  input  1  fetch not ready this cycle
- id_read_en_1  input  1  ID reads register port 1
- id_read_addr_1  input  REG_ADDR_BUS_WIDTH  ID port-1 register address
- id_read_en_2  input  1  ID reads register port 2
- id_read_addr_2  input  REG_ADDR_BUS_WIDTH  ID port-2 register address
- ex_ram_read_flag  input  1  instruction in EX is a load
- ex_write_reg_en  input  1  instruction in EX writes a register
- ex_write_reg_addr  input  REG_ADDR_BUS_WIDTH  EX destination register
- ex_busy  input  1  EX multi-cycle unit not done
- mem_ram_en  input  1  MEM stage accesses RAM this cycle
- mem_ram_ready  input  1  RAM completes access this cycle
- stall  output  6  per-stage stall, bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB
- ram_timeout  output  1  one-cycle pulse when RAM wait is force-released

Behaviour:
- Stall requests are combinational, same cycle:
  - req_if = stall_req_if.
  - req_id = ex_ram_read_flag & ex_write_reg_en & ex_write_reg_addr!=0 & ((id_read_en_1 & addr_1==ex_write_reg_addr) | (id_read_en_2 & addr_2==ex_write_reg_addr)).
  - req_ex = ex_busy.
  - req_mem = mem_wait (see FSM below).
- Stall vector: let k = highest stage index with an active request. Then stall[j]=1 for all j<=k and stall[j]=0 for j>k. No request gives stall=0. stall[5] is never set.
- The stall vector is a pure function of the current inputs and FSM state; it is not registered, so latency is 0 cycles.
- Bubble insertion happens in the stage registers: stall[k]=1 with stall[k+1]=0 produces a bubble. stall_ctrl does not drive bubbles itself.
- Load-use costs exactly one bubble. Once EX holds the bubble, ex_ram_read_flag=0 and req_id drops with no extra state.
- Register 0 never triggers load-use.
- RAM FSM states:
  - IDLE:
    - mem_ram_en & !mem_ram_ready: go to WAIT, cnt=1, mem_wait=1 in this same cycle.
    - Otherwise stay in IDLE, mem_wait=0.
  - WAIT, mem_wait=1 while waiting:
    - mem_ram_ready=1: mem_wait=0 this cycle, go to IDLE.
    - Else if cnt==RAM_TIMEOUT: mem_wait=0, ram_timeout=1 this cycle, go to IDLE.
    - Otherwise cnt+=1.
    - mem_ram_en dropping while in WAIT is a bus error: go to IDLE, mem_wait=0, no pulse.
- A ready and a timeout in the same cycle count as ready; no pulse.
- Simultaneous causes: the highest stage wins the prefix (MEM wait plus load-use gives stall=5'b11111 in bits 0..4). Lower causes stay pending and reassert once the higher cause clears.
- Reset is asynchronous active-low and wins over any FSM state, including mid-WAIT:
  - FSM=IDLE, cnt=0, ram_timeout=0.
  - stall=0, given inputs held at 0 during reset.
- Counter arithmetic is unsigned TIMEOUT_CNT_WIDTH. It never wraps because the FSM leaves WAIT at RAM_TIMEOUT.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and load_use_count[31:0].
  - stall_cycles increments each clk where stall[0]=1.
  - load_use_count increments each clk where req_id=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines file (global_def) gains STALL_BUS_WIDTH=6 and stage indices STALL_PC..STALL_WB (0..5).
- It also gains the RAM FSM state encodings RAM_FSM_IDLE/RAM_FSM_WAIT (1 bit).
- One natural sub-module: ram_wait_fsm, which holds the FSM, cnt and ram_timeout and outputs mem_wait.
- Prefix encoding and load-use compare stay in stall_ctrl.

Test Plan:
1. Reset low mid-WAIT with cnt=5 -> stall=0, ram_timeout=0 immediately. After release, mem_ram_en=1, ready=0 -> stall=6'b011111 in the first cycle.
2. Load-use: ex_ram_read_flag=1, ex_write_reg_en=1, ex_write_reg_addr=5, id_read_en_2=1, id_read_addr_2=5 -> stall=6'b000111 for one cycle. Next cycle, with EX bubbled, stall=0. Repeat with addr 0 -> stall=0.
3. RAM wait: mem_ram_en=1, ready=0 for 3 cycles, then ready=1 -> stall=6'b011111 for 3 cycles, 6'b000000 on the ready cycle, no timeout pulse.
4. Timeout with RAM_TIMEOUT=4: ready held 0 -> stall=6'b011111 for 4 cycles, ram_timeout=1 together with stall=0 on cycle 5, FSM back in IDLE.
5. Priority: ex_busy=1 with stall_req_if=1 -> stall=6'b001111. Drop ex_busy -> stall=6'b000011.
6. With STALL_PERF_CNT_EN: 10 stall cycles including 2 load-use -> stall_cycles=10, load_use_count=2. Preload near max -> saturates at 32'hFFFFFFFF.
